// File: rtl/regfile_dump_reader_if.sv
// Output beat stream of the register-file dump reader: one (addr, data, last)
// beat per valid/ready handshake toward the debug/trace link.
interface regfile_dump_reader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (output out_valid, out_addr, out_data, out_last, input out_ready);
   modport slave  (input out_valid, out_addr, out_data, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: on start, sweeps [first_addr..last_addr] through a
// spare combinational read port and streams each register as an (addr, data)
// beat. The next word is presented on the read port while a beat is pending,
// so a handshake reloads the beat in the same cycle (one beat per cycle).
// Optional: RF_DUMP_CHECKSUM_EN appends a beat (addr 0, XOR of all data, last).
module regfile_dump_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clock_i,
   input  logic                  reset_i,        // active low, asynchronous
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] first_addr_i,
   input  logic [ADDR_WIDTH-1:0] last_addr_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  range_err_o,
   output logic [ADDR_WIDTH-1:0] rf_rd_addr_o,
   input  logic [DATA_WIDTH-1:0] rf_rd_data_i,
   regfile_dump_reader_if.master out_if
);

`ifdef RF_DUMP_CHECKSUM_EN
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_CSUM} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;
`endif

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_q, cur_d;
   logic [ADDR_WIDTH-1:0] end_q, end_d;
   logic                  valid_q, valid_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic                  done_q, done_d;
   logic                  rerr_q, rerr_d;
   logic [ADDR_WIDTH-1:0] cur_inc;
   logic                  hs;

`ifdef RF_DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

   assign cur_inc = cur_q + ADDR_WIDTH'(1);   // wraps modulo 2**ADDR_WIDTH
   assign hs      = valid_q & out_if.out_ready;

   // Next-state, read-port address and beat register updates.
   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      end_d        = end_q;
      valid_d      = valid_q;
      addr_d       = addr_q;
      data_d       = data_q;
      last_d       = last_q;
      done_d       = 1'b0;
      rerr_d       = 1'b0;
      rf_rd_addr_o = '0;
`ifdef RF_DUMP_CHECKSUM_EN
      csum_d       = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (first_addr_i <= last_addr_i) begin
                  cur_d   = first_addr_i;
                  end_d   = last_addr_i;
                  state_d = S_FETCH;
`ifdef RF_DUMP_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end else begin
                  done_d = 1'b1;
                  rerr_d = 1'b1;
               end
            end
         end
         S_FETCH: begin
            rf_rd_addr_o = cur_q;
            data_d       = rf_rd_data_i;
            addr_d       = cur_q;
            valid_d      = 1'b1;
            state_d      = S_SEND;
`ifdef RF_DUMP_CHECKSUM_EN
            last_d       = 1'b0;
`else
            last_d       = (cur_q == end_q);
`endif
         end
         S_SEND: begin
            // Pre-read the following register; on the final beat this may wrap
            // to 0 and is simply not used.
            rf_rd_addr_o = cur_inc;
            if (hs) begin
`ifdef RF_DUMP_CHECKSUM_EN
               csum_d = csum_q ^ data_q;
`endif
               if (cur_q == end_q) begin
`ifdef RF_DUMP_CHECKSUM_EN
                  addr_d  = '0;
                  data_d  = csum_q ^ data_q;
                  last_d  = 1'b1;
                  state_d = S_CSUM;
`else
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
`endif
               end else begin
                  cur_d  = cur_inc;
                  addr_d = cur_inc;
                  data_d = rf_rd_data_i;
`ifdef RF_DUMP_CHECKSUM_EN
                  last_d = 1'b0;
`else
                  last_d = (cur_inc == end_q);
`endif
               end
            end
         end
`ifdef RF_DUMP_CHECKSUM_EN
         S_CSUM: begin
            if (hs) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and beat registers; reset aborts any dump without a done pulse.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         end_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
         done_q  <= done_d;
         rerr_q  <= rerr_d;
      end
   end

`ifdef RF_DUMP_CHECKSUM_EN
   // Running XOR of every emitted data beat.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) csum_q <= '0;
      else          csum_q <= csum_d;
   end
`endif

   assign busy_o           = (state_q != S_IDLE);
   assign done_o           = done_q;
   assign range_err_o      = rerr_q;
   assign out_if.out_valid = valid_q;
   assign out_if.out_addr  = addr_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table of directed dumps plus random dumps,
// each checked against a queue of expected beats built from the register
// file contents, plus stall-hold and asynchronous-reset sequences.
module tb_regfile_dump_reader;
   localparam int DW = 32;
   localparam int AW = 5;
`ifdef RF_DUMP_CHECKSUM_EN
   localparam int CX = 1;
`else
   localparam int CX = 0;
`endif

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   typedef struct {
      int f;
      int l;
      int mode;   // 0 ready=1, 1 random ready, 2 ready low 3 cycles on beat 6
      int cyc;    // cycles from start to done (inclusive)
      bit rerr;
   } vec_t;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b0;
   logic          start_i = 1'b0;
   logic [AW-1:0] first_addr_i = '0;
   logic [AW-1:0] last_addr_i = '0;
   logic          busy_o, done_o, range_err_o;
   logic [AW-1:0] rf_rd_addr_o;
   logic [DW-1:0] rf_rd_data_i;
   logic [DW-1:0] rf [32];

   regfile_dump_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ob ();

   regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .start_i      (start_i),
      .first_addr_i (first_addr_i),
      .last_addr_i  (last_addr_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .range_err_o  (range_err_o),
      .rf_rd_addr_o (rf_rd_addr_o),
      .rf_rd_data_i (rf_rd_data_i),
      .out_if       (ob.master)
   );

   always #5 clock_i = ~clock_i;

   // register file: x0 reads as zero
   always_comb rf_rd_data_i = (rf_rd_addr_o == '0) ? '0 : rf[rf_rd_addr_o];

   int    total = 0;
   int    bad = 0;
   beat_t got[$];
   beat_t exp_q[$];
   bit    busy_seen, valid_seen;
   bit    pv, pr;
   beat_t pb;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // expected beat list from the current register file contents
   task automatic build_exp(input int f, input int l);
      logic [DW-1:0] cs, d;
      exp_q.delete();
      cs = '0;
      if (f > l) return;
      for (int a = f; a <= l; a++) begin
         d = (a == 0) ? '0 : rf[a];
         cs ^= d;
         exp_q.push_back('{a: AW'(a), d: d, l: (CX == 0) && (a == l)});
      end
      if (CX != 0) exp_q.push_back('{a: '0, d: cs, l: 1'b1});
   endtask

   // capture handshakes and check that a stalled beat is held stable
   always @(negedge clock_i) begin
      if (!reset_i) begin
         pv = 1'b0;
      end else begin
         if (pv && !pr)
            chk("hold", {ob.out_valid, ob.out_addr, ob.out_data, ob.out_last}, {1'b1, pb});
         if (ob.out_valid && ob.out_ready)
            got.push_back('{a: ob.out_addr, d: ob.out_data, l: ob.out_last});
         if (busy_o) busy_seen = 1'b1;
         if (ob.out_valid) valid_seen = 1'b1;
         pv = ob.out_valid;
         pr = ob.out_ready;
         pb = '{a: ob.out_addr, d: ob.out_data, l: ob.out_last};
      end
   end

   task automatic run_dump(input int f, input int l, input int mode,
                           output int cyc, output bit rerr);
      int stall = 0;
      bit stalled = 1'b0;
      got.delete();
      busy_seen = 1'b0;
      valid_seen = 1'b0;
      rerr = 1'b0;
      @(posedge clock_i); #1;
      start_i = 1'b1;
      first_addr_i = AW'(f);
      last_addr_i = AW'(l);
      ob.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      first_addr_i = AW'($urandom);   // must not be re-sampled mid-dump
      last_addr_i = AW'($urandom);
      cyc = 1;
      forever begin
         @(negedge clock_i);
         if (done_o) begin
            rerr = range_err_o;
            break;
         end
         @(posedge clock_i); #1;
         cyc++;
         if (mode == 1) ob.out_ready = ($urandom_range(0, 99) < 65);
         else if (mode == 2) begin
            if (!stalled && ob.out_valid && ob.out_addr == AW'(6)) begin
               stalled = 1'b1;
               stall = 3;
            end
            if (stall > 0) begin
               ob.out_ready = 1'b0;
               stall--;
            end else ob.out_ready = 1'b1;
         end
         if (cyc > 400) begin
            chk("done_timeout", 64'(cyc), 64'(0));
            break;
         end
      end
      @(negedge clock_i);
      chk("done_one_cycle", {63'd0, done_o}, 64'd0);
      ob.out_ready = 1'b1;
   endtask

   task automatic check_beats(input bit rerr_exp);
      chk("nbeats", 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < got.size() && i < exp_q.size(); i++)
         chk("beat", 64'(got[i]), 64'(exp_q[i]));
      chk("busy_seen", {63'd0, busy_seen}, {63'd0, !rerr_exp});
      chk("valid_seen", {63'd0, valid_seen}, {63'd0, !rerr_exp});
   endtask

   vec_t vecs[7];

   initial begin
      int  cyc;
      bit  rerr;
      int  f, l;
      vecs[0] = '{f: 5,  l: 7,  mode: 0, cyc: 5 + CX,  rerr: 1'b0};
      vecs[1] = '{f: 5,  l: 7,  mode: 2, cyc: 8 + CX,  rerr: 1'b0};
      vecs[2] = '{f: 9,  l: 3,  mode: 0, cyc: 1,       rerr: 1'b1};
      vecs[3] = '{f: 0,  l: 31, mode: 0, cyc: 34 + CX, rerr: 1'b0};
      vecs[4] = '{f: 5,  l: 6,  mode: 0, cyc: 4 + CX,  rerr: 1'b0};
      vecs[5] = '{f: 31, l: 31, mode: 0, cyc: 3 + CX,  rerr: 1'b0};
      vecs[6] = '{f: 0,  l: 0,  mode: 0, cyc: 3 + CX,  rerr: 1'b0};

      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[5] = 32'hDEADBEEF;
      rf[6] = 32'h12345678;
      rf[7] = 32'h0;
      rf[31] = 32'hFFFFFFFF;
      ob.out_ready = 1'b1;

      // reset state
      #12;
      chk("rst_ctl", {busy_o, done_o, range_err_o, ob.out_valid, ob.out_last},
          5'b00000);
      chk("rst_addr", {ob.out_addr, rf_rd_addr_o}, '0);
      chk("rst_data", 64'(ob.out_data), 64'd0);
      @(negedge clock_i);
      reset_i = 1'b1;
      repeat (2) @(negedge clock_i);
      chk("idle_rdaddr", 64'(rf_rd_addr_o), 64'd0);

      // directed table
      for (int i = 0; i < 7; i++) begin
         build_exp(vecs[i].f, vecs[i].l);
         run_dump(vecs[i].f, vecs[i].l, vecs[i].mode, cyc, rerr);
         chk($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
         chk($sformatf("v%0d_rerr", i), {63'd0, rerr}, {63'd0, vecs[i].rerr});
         check_beats(vecs[i].rerr);
      end

      // asynchronous reset in the middle of a full-range dump
      @(posedge clock_i); #1;
      start_i = 1'b1; first_addr_i = '0; last_addr_i = 5'd31;
      @(posedge clock_i); #1;
      start_i = 1'b0;
      cyc = 0;
      do begin
         @(negedge clock_i);
         cyc++;
      end while (!(ob.out_valid && ob.out_addr == AW'(4)) && cyc < 60);
      chk("mid_reach_beat4", {63'd0, ob.out_valid}, 64'd1);
      #2 reset_i = 1'b0;
      #1;
      chk("mid_rst", {busy_o, done_o, ob.out_valid, ob.out_last}, 4'b0000);
      @(negedge clock_i);
      chk("mid_rst_nodone", {busy_o, done_o, range_err_o}, 3'b000);
      reset_i = 1'b1;
      build_exp(10, 12);
      run_dump(10, 12, 0, cyc, rerr);
      chk("post_rst_cycles", 64'(cyc), 64'(5 + CX));
      check_beats(1'b0);

      // random dumps with random back-pressure
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < 32; i++) rf[i] = $urandom;
         f = $urandom_range(0, 31);
         l = (n % 5 == 4) ? $urandom_range(0, 31) : $urandom_range(f, 31);
         build_exp(f, l);
         run_dump(f, l, 1, cyc, rerr);
         chk("rnd_rerr", {63'd0, rerr}, {63'd0, (f > l)});
         check_beats(f > l);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/trace engine on the reader side of the 32x32 register file. It sits on a spare register-file read port.
- On a start pulse it sweeps a programmed address range [first_addr..last_addr] through the read port. It streams each register out as an (addr, data) beat on a valid/ready interface toward the debug/trace link.
- Used for post-run register dumps and for checking the architectural state in simulation.

Parameters:
- DATA_WIDTH, 32, width of register-file data and out_data.
- ADDR_WIDTH, 5, register address width. The register file holds 2**ADDR_WIDTH entries.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Asserted when 0.
- start  input  1  begin a dump. Sampled only in IDLE.
- first_addr  input  ADDR_WIDTH  first register to dump. Sampled with start.
- last_addr  input  ADDR_WIDTH  last register to dump, inclusive. Sampled with start.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse when a dump completes or is rejected.
- range_err  output  1  one-cycle pulse, coincident with done, when first_addr > last_addr.
- rf_rd_addr  output  ADDR_WIDTH  address to the register-file read port.
- rf_rd_data  input  DATA_WIDTH  combinational read data for rf_rd_addr.
- out_valid  output  1  output beat valid.
- out_ready  input  1  sink accepts the beat.
- out_addr  output  ADDR_WIDTH  register index of the current beat.
- out_data  output  DATA_WIDTH  register contents of the current beat.
- out_last  output  1  final beat of the dump.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE.
  - busy, done, range_err, out_valid and out_last are 0.
  - out_addr, out_data and rf_rd_addr are 0.
  - The internal cur and end registers are 0.
  - Reset asserted mid-dump aborts the dump immediately. No done pulse is produced.
- States: IDLE, FETCH, SEND, plus CSUM when the optional feature is compiled in.
- IDLE:
  - busy=0 and rf_rd_addr=0.
  - On start=1 with first_addr <= last_addr: latch cur=first_addr and end=last_addr, then go to FETCH. busy=1 from the next cycle.
  - On start=1 with first_addr > last_addr: in the next cycle pulse done=1 and range_err=1 for one cycle and stay in IDLE. No beats are emitted.
- FETCH (exactly one cycle):
  - rf_rd_addr=cur.
  - At the clock edge: out_data<=rf_rd_data, out_addr<=cur, out_last<=(cur==end), out_valid<=1. Go to SEND.
- SEND:
  - rf_rd_addr=cur+1, modulo 2**ADDR_WIDTH. The next word is presented combinationally so a handshake can reload in the same cycle.
  - While out_valid=1 and out_ready=0, out_addr, out_data and out_last are held stable.
  - Handshake (out_valid & out_ready) with out_last=0:
    - cur<=cur+1, out_addr<=cur+1, out_data<=rf_rd_data, out_last<=(cur+1==end).
    - Stay in SEND.
    - Sustained throughput is one beat per cycle.
  - Handshake with out_last=1:
    - out_valid<=0 and out_last<=0.
    - done pulses 1 in the next cycle and busy drops together with it.
    - Go to IDLE.
- Latency: start to first out_valid is 2 cycles. A dump of N registers with out_ready held at 1 takes N+2 cycles from start to done.
- Wrap-around: when end=31, rf_rd_addr=cur+1 wraps to 0 on the final beat. That value is ignored and never emitted.
- Register 0 is dumped as read; the register file returns 0 for it.
- start is ignored while busy=1. first_addr and last_addr are not re-sampled during a dump.
- Data is sampled at fetch or handshake time. Writes to the register file during a dump are visible if they land before that register is sampled.

Optional Feature:
- Macro: RF_DUMP_CHECKSUM_EN.
- When defined:
  - A DATA_WIDTH running XOR of every emitted out_data is kept. It is cleared on start.
  - The data beats carry out_last=0.
  - After the last data handshake, the block enters CSUM and emits one extra beat with out_addr=0, out_data=checksum and out_last=1. The beat is held until out_ready=1.
  - After that handshake it returns to IDLE, and done pulses in the next cycle.
  - Latency is one beat longer.
- When undefined: there is no checksum logic and no CSUM state, and behaviour is as above.

Test Plan:
- Reset, then preload x5=0xDEADBEEF, x6=0x12345678 and x7=0x0; start with first=5, last=7, out_ready=1 -> beats (5,0xDEADBEEF,0), (6,0x12345678,0), (7,0x0,1) on consecutive cycles; done pulses 1 cycle after the last beat; total 5 cycles from start.
- Same dump with out_ready low for 3 cycles during beat 6 -> beat 6 held stable for all 3 cycles; no beat lost or duplicated; order preserved.
- Start with first=9, last=3 -> done=1 and range_err=1 for one cycle; out_valid never rises; busy stays 0.
- Full range first=0, last=31 with x31=0xFFFFFFFF -> 32 beats; first beat (0,0x0); last beat (31,0xFFFFFFFF,1); no beat with addr 0 after addr 31.
- Drive reset=0 asynchronously mid-dump at beat 4 -> out_valid=0, busy=0 and done=0 immediately; a new start afterwards dumps correctly from its first_addr.
- With RF_DUMP_CHECKSUM_EN, dump x5..x6 as above -> 3 beats; the final beat is (0, 0xDEADBEEF^0x12345678=0xCC99E897, last=1).
